// File: rtl/timer_pkg.sv
// Shared constants, slot encoding and the 16x32 seven-segment style digit font
// used by the on-screen timer (and reusable by other numeric displays).
`default_nettype none

package timer_pkg;

    localparam int DIGIT_W = 16;
    localparam int DIGIT_H = 32;
    localparam int FIELD_W = 64;

    typedef enum logic [1:0] {
        SLOT_MIN   = 2'd0,
        SLOT_COLON = 2'd1,
        SLOT_TENS  = 2'd2,
        SLOT_UNITS = 2'd3
    } slot_t;

    // Segment sets per digit, bit order {g,f,e,d,c,b,a}.
    localparam logic [0:9][6:0] SEG_CODE = {
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
    };

    // Row word: bit 15 is the leftmost pixel column.
    typedef bit [0:9][0:31][15:0] bitmap_t;

    // Bars are 4 px thick; columns 0,1,14,15 are spacing between glyphs.
    function automatic bit [15:0] seg_row(input logic [6:0] segs, input int r);
        bit [15:0] v;
        v = '0;
        if (segs[0] && (r < 4))              v |= 16'h3FFC;
        if (segs[1] && (r < 16))             v |= 16'h003C;
        if (segs[2] && (r >= 16))            v |= 16'h003C;
        if (segs[3] && (r >= 28))            v |= 16'h3FFC;
        if (segs[4] && (r >= 16))            v |= 16'h3C00;
        if (segs[5] && (r < 16))             v |= 16'h3C00;
        if (segs[6] && (r >= 14) && (r < 18)) v |= 16'h3FFC;
        return v;
    endfunction

    function automatic bitmap_t build_bitmap();
        bitmap_t bm;
        for (int d = 0; d < 10; d++) begin
            for (int r = 0; r < DIGIT_H; r++) begin
                bm[d][r] = seg_row(SEG_CODE[d], r);
            end
        end
        return bm;
    endfunction

    localparam bitmap_t DIGIT_BITMAP = build_bitmap();

endpackage

`default_nettype wire

// File: rtl/digit_glyph_rom.sv
// Combinational glyph lookup: one pixel of a 16x32 decimal digit.
// Codes above 9 render blank so callers can use them as "no digit".
`default_nettype none

module digit_glyph_rom
    import timer_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [4:0] row,
    input  logic [3:0] col,
    output logic       lit
);

    always_comb begin
        lit = 1'b0;
        if (digit <= 4'd9) begin
            lit = DIGIT_BITMAP[digit][row][4'(DIGIT_W - 1) - col];
        end
    end

endmodule

`default_nettype wire

// File: rtl/timer_digits_draw.sv
// Renders the M:SS countdown as a 64x32 field for the VGA mux: frame-latched
// digits, 2-clock pixel pipeline, amber under 10 s, blinking after game over.
`default_nettype none

module timer_digits_draw
    import timer_pkg::*;
#(
    parameter logic [10:0] TOPLEFT_X   = 11'd288,
    parameter logic [10:0] TOPLEFT_Y   = 11'd8,
    parameter logic [7:0]  DIGIT_COLOR = 8'hFF,
    parameter logic [7:0]  WARN_COLOR  = 8'hF0
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        startOfFrame,
    input  logic        one_sec,
    input  logic        game_over,
    input  logic [3:0]  minutesDig,
    input  logic [3:0]  secondSecondsDig,
    input  logic [3:0]  firstSecondsDig,
    output logic        timerDrawingRequest,
    output logic [7:0]  timerRGB
);

    logic [3:0] lat_min;
    logic [3:0] lat_tens;
    logic [3:0] lat_units;
    logic       lat_game_over;
    logic       frame_valid;
    logic       blink_on;

    // frame_valid keeps the display dark after a reset until digits are re-latched.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            lat_min       <= 4'd2;
            lat_tens      <= 4'd0;
            lat_units     <= 4'd0;
            lat_game_over <= 1'b0;
            frame_valid   <= 1'b0;
        end else if (startOfFrame) begin
            lat_min       <= minutesDig;
            lat_tens      <= secondSecondsDig;
            lat_units     <= firstSecondsDig;
            lat_game_over <= game_over;
            frame_valid   <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            blink_on <= 1'b1;
        end else if (!lat_game_over) begin
            blink_on <= 1'b1;
        end else if (one_sec) begin
            blink_on <= ~blink_on;
        end
    end

    // Offsets only need the low bits; the full-width compares decide "inside".
    logic [5:0] field_x;
    logic [4:0] field_y;
    logic       inside_x;
    logic       inside_y;
    slot_t      slot_sel;
    logic [3:0] digit_sel;

    assign field_x  = pixelX[5:0] - TOPLEFT_X[5:0];
    assign field_y  = pixelY[4:0] - TOPLEFT_Y[4:0];
    assign inside_x = (pixelX >= TOPLEFT_X) &&
                      ({1'b0, pixelX} < ({1'b0, TOPLEFT_X} + 12'(FIELD_W)));
    assign inside_y = (pixelY >= TOPLEFT_Y) &&
                      ({1'b0, pixelY} < ({1'b0, TOPLEFT_Y} + 12'(DIGIT_H)));
    assign slot_sel = slot_t'(field_x[5:4]);

    always_comb begin
        digit_sel = 4'hF;
        unique case (slot_sel)
            SLOT_MIN:   digit_sel = lat_min;
            SLOT_COLON: digit_sel = 4'hF;
            SLOT_TENS:  digit_sel = lat_tens;
            SLOT_UNITS: digit_sel = lat_units;
        endcase
    end

    logic       s1_valid;
    logic       s1_inside;
    slot_t      s1_slot;
    logic [3:0] s1_col;
    logic [4:0] s1_row;
    logic [3:0] s1_digit;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            s1_valid  <= 1'b0;
            s1_inside <= 1'b0;
            s1_slot   <= SLOT_MIN;
            s1_col    <= 4'd0;
            s1_row    <= 5'd0;
            s1_digit  <= 4'hF;
        end else begin
            s1_valid  <= frame_valid;
            s1_inside <= inside_x & inside_y;
            s1_slot   <= slot_sel;
            s1_col    <= field_x[3:0];
            s1_row    <= field_y;
            s1_digit  <= digit_sel;
        end
    end

    logic glyph_lit;
    logic colon_lit;
    logic pixel_lit;
    logic request_next;
    logic warn;

    digit_glyph_rom u_glyph (
        .digit (s1_digit),
        .row   (s1_row),
        .col   (s1_col),
        .lit   (glyph_lit)
    );

    assign colon_lit = (s1_col >= 4'd6) && (s1_col <= 4'd9) &&
                       (((s1_row >= 5'd8)  && (s1_row <= 5'd11)) ||
                        ((s1_row >= 5'd20) && (s1_row <= 5'd23)));
    assign pixel_lit    = (s1_slot == SLOT_COLON) ? colon_lit : glyph_lit;
    assign request_next = s1_valid & s1_inside & pixel_lit & blink_on;
    assign warn         = (lat_min == 4'd0) && (lat_tens == 4'd0);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            timerDrawingRequest <= 1'b0;
            timerRGB            <= 8'h00;
        end else begin
            timerDrawingRequest <= request_next;
            if (!request_next) begin
                timerRGB <= 8'h00;
            end else if (warn) begin
                timerRGB <= WARN_COLOR;
            end else begin
                timerRGB <= DIGIT_COLOR;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_timer_digits_draw.sv
// Directed self-checking bench for timer_digits_draw with hand-computed pixels.
`default_nettype none

module tb_timer_digits_draw;

    logic        clk = 1'b0;
    logic        resetN;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        startOfFrame;
    logic        one_sec;
    logic        game_over;
    logic [3:0]  minutesDig;
    logic [3:0]  secondSecondsDig;
    logic [3:0]  firstSecondsDig;
    logic        timerDrawingRequest;
    logic [7:0]  timerRGB;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    timer_digits_draw dut (
        .clk                 (clk),
        .resetN              (resetN),
        .pixelX              (pixelX),
        .pixelY              (pixelY),
        .startOfFrame        (startOfFrame),
        .one_sec             (one_sec),
        .game_over           (game_over),
        .minutesDig          (minutesDig),
        .secondSecondsDig    (secondSecondsDig),
        .firstSecondsDig     (firstSecondsDig),
        .timerDrawingRequest (timerDrawingRequest),
        .timerRGB            (timerRGB)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pixel is presented for one clock only; outputs sampled two clocks later.
    task automatic expect_px(input string tag, input int dx, input int dy,
                             input logic req, input logic [7:0] rgb);
        @(negedge clk);
        pixelX = 11'(288 + dx);
        pixelY = 11'(8 + dy);
        @(negedge clk);
        pixelX = 11'd0;
        pixelY = 11'd0;
        @(negedge clk);
        check({tag, "_req"}, 32'(timerDrawingRequest), 32'(req));
        check({tag, "_rgb"}, 32'(timerRGB), 32'(rgb));
    endtask

    task automatic frame(input logic [3:0] m, input logic [3:0] t,
                         input logic [3:0] u, input logic go);
        @(negedge clk);
        minutesDig       = m;
        secondSecondsDig = t;
        firstSecondsDig  = u;
        game_over        = go;
        startOfFrame     = 1'b1;
        @(negedge clk);
        startOfFrame     = 1'b0;
    endtask

    task automatic pulse_sec();
        @(negedge clk);
        one_sec = 1'b1;
        @(negedge clk);
        one_sec = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN           = 1'b0;
        pixelX           = 11'd0;
        pixelY           = 11'd0;
        startOfFrame     = 1'b0;
        one_sec          = 1'b0;
        game_over        = 1'b0;
        minutesDig       = 4'd2;
        secondSecondsDig = 4'd0;
        firstSecondsDig  = 4'd0;
        repeat (3) @(negedge clk);
        check("rst_req", 32'(timerDrawingRequest), 32'd0);
        check("rst_rgb", 32'(timerRGB), 32'd0);
        resetN = 1'b1;

        // No frame latched yet: stays dark
        expect_px("pre_frame", 5, 0, 1'b0, 8'h00);

        // Reset digits 2:00 latched by the first frame; '2' top bar at col 5
        frame(4'd2, 4'd0, 4'd0, 1'b0);
        expect_px("min2_top", 5, 0, 1'b1, 8'hFF);
        expect_px("colon_dot", 24, 8, 1'b1, 8'hFF);
        expect_px("colon_off", 17, 9, 1'b0, 8'h00);
        expect_px("colon_low", 22, 23, 1'b1, 8'hFF);

        // 1:59 -> 1:58 mid-frame; lower-left bar (col 3,row 20) of units only on '8'
        frame(4'd1, 4'd5, 4'd9, 1'b0);
        expect_px("units9", 51, 20, 1'b0, 8'h00);
        expect_px("min1_right", 12, 5, 1'b1, 8'hFF);
        @(negedge clk);
        firstSecondsDig = 4'd8;
        expect_px("units_held", 51, 20, 1'b0, 8'h00);
        frame(4'd1, 4'd5, 4'd8, 1'b0);
        expect_px("units8", 51, 20, 1'b1, 8'hFF);

        // Under 10 s: amber
        frame(4'd0, 4'd0, 4'd9, 1'b0);
        expect_px("warn_min", 5, 0, 1'b1, 8'hF0);
        expect_px("warn_units", 53, 0, 1'b1, 8'hF0);
        frame(4'd0, 4'd1, 4'd0, 1'b0);
        expect_px("ten_sec", 5, 0, 1'b1, 8'hFF);

        // Non-decimal code renders blank
        frame(4'hA, 4'd1, 4'd0, 1'b0);
        expect_px("blank_A", 5, 0, 1'b0, 8'h00);

        // Field boundaries with 0:10
        frame(4'd0, 4'd1, 4'd0, 1'b0);
        expect_px("left_out", -1, 0, 1'b0, 8'h00);
        expect_px("right_out", 64, 0, 1'b0, 8'h00);
        expect_px("below_out", 5, 32, 1'b0, 8'h00);
        expect_px("above_out", 5, -1, 1'b0, 8'h00);
        expect_px("corner_in", 61, 31, 1'b1, 8'hFF);

        // Game over blinking
        frame(4'd0, 4'd1, 4'd0, 1'b1);
        expect_px("go_start", 5, 0, 1'b1, 8'hFF);
        pulse_sec();
        expect_px("blink1", 5, 0, 1'b0, 8'h00);
        pulse_sec();
        expect_px("blink2", 5, 0, 1'b1, 8'hFF);
        pulse_sec();
        expect_px("blink3", 5, 0, 1'b0, 8'h00);
        pulse_sec();
        expect_px("blink4", 5, 0, 1'b1, 8'hFF);
        pulse_sec();
        expect_px("blink5", 5, 0, 1'b0, 8'h00);
        frame(4'd0, 4'd1, 4'd0, 1'b0);
        expect_px("go_clear", 5, 0, 1'b1, 8'hFF);
        pulse_sec();
        expect_px("steady", 5, 0, 1'b1, 8'hFF);

        // Reset mid-scan: immediate dark, stays dark until the next frame
        frame(4'd2, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        pixelX = 11'(288 + 5);
        pixelY = 11'(8);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_req", 32'(timerDrawingRequest), 32'd1);
        #2 resetN = 1'b0;
        #1;
        check("mid_rst_req", 32'(timerDrawingRequest), 32'd0);
        check("mid_rst_rgb", 32'(timerRGB), 32'd0);
        @(negedge clk);
        resetN = 1'b1;
        expect_px("post_rst", 5, 0, 1'b0, 8'h00);
        frame(4'd2, 4'd0, 4'd0, 1'b0);
        expect_px("relatched", 5, 0, 1'b1, 8'hFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
